// File: rtl/icache_line_fill.sv
// I-cache refill engine: fetches one line as BEATS bus beats, assembles it,
// then writes line and tag into the data array and tag store in one cycle.
module icache_line_fill #(
    parameter int ADR_W   = 32,
    parameter int IDX_W   = 10,
    parameter int BEAT_W  = 64,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_i,
    input  logic [ADR_W-1:0]        miss_adr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic [ADR_W-1:0]        adr_o,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic [BEAT_W-1:0]       dat_i,
    output logic                    wr_o,
    output logic [IDX_W-1:0]        wadr_o,
    output logic [BEAT_W*BEATS-1:0] line_o,
    output logic [ADR_W-IDX_W-6:0]  tag_o
);

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int BOFF_W = $clog2(BEAT_W / 8);
    localparam int BCNT_W = $clog2(BEATS);
    localparam int OFF_W  = BOFF_W + BCNT_W;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADR_W-OFF_W-1:0] line_base;
    logic [BCNT_W-1:0]   beat;
    logic [TCNT_W-1:0]   tcnt;
    logic [TCNT_W-1:0]   tcnt_inc;
    logic [LINE_W-1:0]   buffer;
    logic [LINE_W-1:0]   fill_line;
    logic                last_beat;
    logic                unused_adr_bits;

    // Offset bits inside the line are irrelevant: the fill always starts at beat 0.
    assign unused_adr_bits = ^miss_adr_i[OFF_W-1:0];

    assign last_beat = (beat == BCNT_W'(BEATS - 1));
    assign tcnt_inc  = tcnt + TCNT_W'(1);
    assign adr_o     = (state == FETCH) ? {line_base, beat, {BOFF_W{1'b0}}} : '0;

    always_comb begin
        fill_line = buffer;
        fill_line[beat*BEAT_W +: BEAT_W] = dat_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        wr_o      = 1'b0;
        case (state)
            IDLE: begin
                if (miss_i) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy_o = 1'b1;
                cyc_o  = 1'b1;
                stb_o  = 1'b1;
                // A bus error wins over a simultaneous acknowledge.
                if (err_i) begin
                    state_nxt = ERR;
                end else if (ack_i) begin
                    if (last_beat) begin
                        state_nxt = WRITE;
                    end
                end else if (tcnt_inc == TCNT_W'(TIMEOUT)) begin
                    state_nxt = ERR;
                end
            end
            WRITE: begin
                busy_o    = 1'b1;
                wr_o      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                busy_o    = 1'b1;
                err_o     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write-side outputs load only on the final beat so they hold outside WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_base <= '0;
            beat      <= '0;
            tcnt      <= '0;
            buffer    <= '0;
            line_o    <= '0;
            wadr_o    <= '0;
            tag_o     <= '0;
        end else begin
            if (state == IDLE && miss_i) begin
                line_base <= miss_adr_i[ADR_W-1:OFF_W];
                beat      <= '0;
                tcnt      <= '0;
                buffer    <= '0;
            end
            if (state == FETCH && !err_i) begin
                if (ack_i) begin
                    buffer <= fill_line;
                    tcnt   <= '0;
                    if (last_beat) begin
                        line_o <= fill_line;
                        wadr_o <= line_base[IDX_W-1:0];
                        tag_o  <= line_base[ADR_W-OFF_W-1:IDX_W];
                    end else begin
                        beat <= beat + BCNT_W'(1);
                    end
                end else begin
                    tcnt <= tcnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: table of line fills plus hand-written
// sequences for timeout, miss-while-busy and reset in the middle of a fill.
module tb_icache_line_fill;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_i;
    logic [31:0]  miss_adr_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic         cyc_o;
    logic         stb_o;
    logic [31:0]  adr_o;
    logic         ack_i;
    logic         err_i;
    logic [63:0]  dat_i;
    logic         wr_o;
    logic [9:0]   wadr_o;
    logic [255:0] line_o;
    logic [16:0]  tag_o;

    int total = 0;
    int bad   = 0;
    int wr_seen   = 0;
    int done_seen = 0;
    int err_seen  = 0;

    typedef struct {
        logic [31:0]      adr;
        int               waits;
        int               err_beat;
        logic [3:0][63:0] data;
        logic [31:0]      exp_base;
        logic [9:0]       exp_wadr;
        logic [16:0]      exp_tag;
        logic [255:0]     exp_line;
    } fill_vec_t;

    fill_vec_t vecs[5];

    icache_line_fill dut (
        .clk(clk), .rst(rst), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cyc_o(cyc_o),
        .stb_o(stb_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i),
        .dat_i(dat_i), .wr_o(wr_o), .wadr_o(wadr_o), .line_o(line_o),
        .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, used to prove pulses occur exactly once or never.
    always @(negedge clk) begin
        if (wr_o === 1'b1) wr_seen++;
        if (done_o === 1'b1) done_seen++;
        if (err_o === 1'b1) err_seen++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " busy_o"}, 256'(busy_o), 256'(0));
        check_output({tag, " cyc_o"},  256'(cyc_o),  256'(0));
        check_output({tag, " stb_o"},  256'(stb_o),  256'(0));
        check_output({tag, " adr_o"},  256'(adr_o),  256'(0));
        check_output({tag, " wr_o"},   256'(wr_o),   256'(0));
        check_output({tag, " done_o"}, 256'(done_o), 256'(0));
        check_output({tag, " err_o"},  256'(err_o),  256'(0));
        check_output({tag, " wadr_o"}, 256'(wadr_o), 256'(0));
        check_output({tag, " tag_o"},  256'(tag_o),  256'(0));
        check_output({tag, " line_o"}, line_o,       256'(0));
    endtask

    // Runs one fill from IDLE; called at #1 after a rising edge.
    task automatic apply_stimulus(input fill_vec_t v, input string tag);
        int wr0, done0, err0;
        logic [31:0] exp_adr;
        wr0 = wr_seen; done0 = done_seen; err0 = err_seen;
        miss_i = 1'b1;
        miss_adr_i = v.adr;
        next_cycle();
        miss_i = 1'b0;
        miss_adr_i = 32'hDEAD_BEEF;
        for (int b = 0; b < 4; b++) begin
            exp_adr = v.exp_base + 32'(b * 8);
            for (int w = 0; w <= v.waits; w++) begin
                check_output({tag, " adr_o"}, 256'(adr_o), 256'(exp_adr));
                check_output({tag, " stb_o"}, 256'(stb_o), 256'(1));
                if (w == v.waits) begin
                    ack_i = 1'b1;
                    dat_i = v.data[b];
                    err_i = (b == v.err_beat);
                end
                next_cycle();
                ack_i = 1'b0;
                err_i = 1'b0;
                dat_i = '0;
            end
            if (b == v.err_beat) break;
        end
        if (v.err_beat >= 0) begin
            check_output({tag, " err_o"}, 256'(err_o), 256'(1));
            check_output({tag, " cyc_o in ERR"}, 256'(cyc_o), 256'(0));
            check_output({tag, " wr_o in ERR"}, 256'(wr_o), 256'(0));
            next_cycle();
            check_output({tag, " busy_o after ERR"}, 256'(busy_o), 256'(0));
            check_output({tag, " wr pulses"},   256'(wr_seen - wr0),     256'(0));
            check_output({tag, " done pulses"}, 256'(done_seen - done0), 256'(0));
            check_output({tag, " err pulses"},  256'(err_seen - err0),   256'(1));
        end else begin
            check_output({tag, " wr_o"},   256'(wr_o),   256'(1));
            check_output({tag, " cyc_o in WRITE"}, 256'(cyc_o), 256'(0));
            check_output({tag, " done_o early"}, 256'(done_o), 256'(0));
            check_output({tag, " wadr_o"}, 256'(wadr_o), 256'(v.exp_wadr));
            check_output({tag, " tag_o"},  256'(tag_o),  256'(v.exp_tag));
            check_output({tag, " line_o"}, line_o,       v.exp_line);
            // Bus activity outside FETCH must be ignored.
            ack_i = 1'b1;
            err_i = 1'b1;
            dat_i = 64'hBADB_ADBA_DBAD_BADB;
            next_cycle();
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = '0;
            check_output({tag, " done_o"}, 256'(done_o), 256'(1));
            check_output({tag, " err_o in DONE"}, 256'(err_o), 256'(0));
            check_output({tag, " busy_o in DONE"}, 256'(busy_o), 256'(1));
            check_output({tag, " line_o hold"}, line_o, v.exp_line);
            next_cycle();
            check_output({tag, " busy_o after DONE"}, 256'(busy_o), 256'(0));
            check_output({tag, " wr pulses"},   256'(wr_seen - wr0),     256'(1));
            check_output({tag, " done pulses"}, 256'(done_seen - done0), 256'(1));
            check_output({tag, " err pulses"},  256'(err_seen - err0),   256'(0));
        end
    endtask

    initial begin
        int n;
        int wr0;
        fill_vec_t v;
        rst = 1'b1;
        miss_i = 1'b0;
        miss_adr_i = '0;
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = '0;

        vecs[0] = '{adr: 32'h0001_2345, waits: 0, err_beat: -1,
                    data: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    exp_base: 32'h0001_2340, exp_wadr: 10'h11A, exp_tag: 17'h2,
                    exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{adr: 32'h8765_43F5, waits: 3, err_beat: -1,
                    data: {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                           64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
                    exp_base: 32'h8765_43E0, exp_wadr: 10'h21F, exp_tag: 17'h10ECA,
                    exp_line: {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}};
        vecs[2] = '{adr: 32'h0000_0040, waits: 0, err_beat: 2,
                    data: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    exp_base: 32'h0000_0040, exp_wadr: 10'h0, exp_tag: 17'h0,
                    exp_line: 256'h0};
        vecs[3] = '{adr: 32'hFFFF_FFE7, waits: 1, err_beat: -1,
                    data: {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                    exp_base: 32'hFFFF_FFE0, exp_wadr: 10'h3FF, exp_tag: 17'h1FFFF,
                    exp_line: {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                               64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}};
        vecs[4] = '{adr: 32'h0000_001F, waits: 2, err_beat: -1,
                    data: {64'h8000_0000_0000_0000, 64'h3, 64'h2, 64'h1},
                    exp_base: 32'h0000_0000, exp_wadr: 10'h0, exp_tag: 17'h0,
                    exp_line: {64'h8000_0000_0000_0000, 64'h3, 64'h2, 64'h1}};

        #2 rst = 1'b0;
        #6;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        check_output("idle busy_o", 256'(busy_o), 256'(0));

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: strobe never acknowledged, abort after TIMEOUT cycles in FETCH.
        $display("[TB] timeout sequence");
        wr0 = wr_seen;
        miss_i = 1'b1;
        miss_adr_i = 32'h0000_0100;
        next_cycle();
        miss_i = 1'b0;
        n = 1;
        check_output("timeout adr_o", 256'(adr_o), 256'(32'h0000_0100));
        while (n < 400 && err_o !== 1'b1) begin
            next_cycle();
            n++;
        end
        check_output("timeout err cycle", 256'(n), 256'(256));
        check_output("timeout cyc_o", 256'(cyc_o), 256'(0));
        next_cycle();
        check_output("timeout busy_o after", 256'(busy_o), 256'(0));
        check_output("timeout wr pulses", 256'(wr_seen - wr0), 256'(0));

        // Miss while busy: second miss is ignored, then re-accepted once IDLE.
        $display("[TB] miss-while-busy sequence");
        miss_i = 1'b1;
        miss_adr_i = 32'h0001_2345;
        next_cycle();
        miss_i = 1'b0;
        ack_i = 1'b1;
        dat_i = 64'h0101_0101_0101_0101;
        next_cycle();
        miss_i = 1'b1;
        miss_adr_i = 32'h5555_5555;
        for (int b = 1; b < 4; b++) begin
            check_output("busy-miss adr_o", 256'(adr_o), 256'(32'h0001_2340 + 32'(b * 8)));
            dat_i = {8{8'(b + 1)}};
            next_cycle();
        end
        ack_i = 1'b0;
        dat_i = '0;
        check_output("busy-miss wr_o", 256'(wr_o), 256'(1));
        check_output("busy-miss wadr_o", 256'(wadr_o), 256'(10'h11A));
        check_output("busy-miss tag_o", 256'(tag_o), 256'(17'h2));
        check_output("busy-miss line_o", line_o,
                     {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                      64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});
        next_cycle();
        check_output("busy-miss done_o", 256'(done_o), 256'(1));
        next_cycle();
        check_output("busy-miss idle busy_o", 256'(busy_o), 256'(0));
        next_cycle();
        check_output("busy-miss re-accept busy_o", 256'(busy_o), 256'(1));
        check_output("busy-miss re-accept adr_o", 256'(adr_o), 256'(32'h5555_5540));
        miss_i = 1'b0;

        // Reset after two beats of the re-accepted fill: everything clears at once.
        $display("[TB] reset mid-fill sequence");
        ack_i = 1'b1;
        dat_i = 64'hDEAD_DEAD_DEAD_0000;
        next_cycle();
        dat_i = 64'hDEAD_DEAD_DEAD_0001;
        next_cycle();
        ack_i = 1'b0;
        dat_i = '0;
        check_output("pre-reset cyc_o", 256'(cyc_o), 256'(1));
        rst = 1'b0;
        #1;
        check_all_zero("mid-fill reset");
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        check_output("post-reset busy_o", 256'(busy_o), 256'(0));
        v = vecs[0];
        v.data = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                  64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        v.exp_line = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                      64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        apply_stimulus(v, "post-reset fill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Instruction-cache refill engine that sits directly upstream of the 256x1024 I-cache data array.
- On a fetch miss it reads one 256-bit line from the system bus as four 64-bit beats, assembles the line, and writes it into the data array and tag store in a single cycle.
- It reports completion or bus error to the fetch stage.

Parameters:
- ADR_W, 32, byte address width.
- IDX_W, 10, line index width; matches data array depth of 1024.
- BEAT_W, 64, bus data width.
- BEATS, 4, beats per line; LINE_W = BEAT_W*BEATS = 256.
- TIMEOUT, 255, cycles without ack before the fill aborts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- miss_i  in  1  fetch miss request, level-sampled in IDLE.
- miss_adr_i  in  ADR_W  missing byte address.
- busy_o  out  1  fill in progress (any state other than IDLE).
- done_o  out  1  one-cycle pulse: line written, readable from the data array.
- err_o  out  1  one-cycle pulse: fill aborted.
- cyc_o  out  1  bus cycle active.
- stb_o  out  1  bus strobe.
- adr_o  out  ADR_W  beat byte address.
- ack_i  in  1  beat acknowledge, with valid dat_i.
- err_i  in  1  bus error.
- dat_i  in  BEAT_W  beat data.
- wr_o  out  1  data array and tag write enable.
- wadr_o  out  IDX_W  line index = line_adr[IDX_W+4:5].
- line_o  out  256  assembled line; ICacheLine layout.
- tag_o  out  ADR_W-IDX_W-5  tag = line_adr[ADR_W-1:IDX_W+5].

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - All outputs 0, including line buffer, beat counter, timeout counter and latched address.
- States: IDLE, FETCH, WRITE, DONE, ERR.
- IDLE:
  - If miss_i=1, latch line_adr = {miss_adr_i[ADR_W-1:5], 5'b0}, clear beat counter and timeout counter, go to FETCH.
  - The first bus strobe appears in the next cycle.
- FETCH:
  - cyc_o=1, stb_o=1, adr_o = line_adr + beat*8.
  - On ack_i=1 (err_i=0):
    - Capture dat_i into buffer[beat*64 +: 64].
    - Clear the timeout counter.
    - If beat==BEATS-1, go to WRITE; otherwise increment beat.
  - Beats fill in ascending address order. At most one beat is accepted per cycle, and stb_o remains high between beats.
  - Without ack, the timeout counter increments each cycle. When it reaches TIMEOUT, go to ERR.
- WRITE (exactly one cycle):
  - cyc_o=0, stb_o=0, wr_o=1.
  - wadr_o and tag_o come from line_adr; line_o=buffer.
  - Go to DONE.
- DONE (one cycle): done_o=1, go to IDLE. The data array's registered read of wadr_o issued in DONE returns the new line.
- ERR (one cycle): err_o=1, go to IDLE. No data array or tag write occurs; the partial buffer is discarded.
- Simultaneous events:
  - err_i=1 in FETCH goes to ERR regardless of ack_i; the beat is not captured.
  - ack_i or err_i outside FETCH is ignored.
  - miss_i is ignored outside IDLE.
- Minimum miss-to-done_o latency: 1 (latch) + 4 (beats) + 1 (WRITE) + 1 = done_o in the 7th cycle after miss_i is sampled, with zero wait states.
- wadr_o, tag_o and line_o hold their values outside WRITE. Consumers must qualify them with wr_o.
- Reset during any state aborts immediately: cyc_o drops asynchronously, with no write and no done_o/err_o pulse.

Test Plan:
- Zero-wait fill: miss_adr_i=0x0001_2345, ack_i every cycle, dat_i=0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - adr_o sequence is 0x12340, 0x12348, 0x12350, 0x12358.
  - wr_o=1 with wadr_o=0x11A, tag_o=0x2, line_o={0x44..,0x33..,0x22..,0x11..}.
  - done_o in cycle 7; busy_o falls the cycle after done_o.
- Wait states: 3 idle cycles before each ack.
  - adr_o holds per beat and the line is correct.
  - done_o arrives 12 cycles later than the zero-wait case.
- Bus error: err_i=1 together with ack_i on beat 2.
  - err_o pulses once; wr_o and done_o never assert.
  - The next miss fills correctly.
- Timeout: no ack after the first strobe.
  - err_o pulses after TIMEOUT cycles; cyc_o=0; wr_o never asserts.
- Miss while busy: assert miss_i with a different address during FETCH.
  - It is ignored; the original line is written.
  - A held miss_i is accepted again in IDLE after done_o.
- Reset mid-fill: rst=0 after beat 1.
  - All outputs are 0 immediately.
  - After release with a new miss, the line contains only the new data, with no stale beats.
